// File: rtl/timer_pkg.sv
// Shared types and BCD limits for the mm:ss countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } timer_state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [7:0] MIN_MAX      = 8'h99;

  // dec is exclusive with the increments; both increments may be set together.
  typedef struct packed {
    logic dec;
    logic inc_min;
    logic inc_sec;
  } step_mode_t;

endpackage

// File: rtl/bcd_mmss_step.sv
// Combinational one-step BCD mm:ss update: decrement with borrow, or
// independent wrap-around increments of the minute and second fields.
module bcd_mmss_step
  import timer_pkg::*;
(
  input  logic [15:0] val,
  input  step_mode_t  mode,
  output logic [15:0] next,
  output logic        is_one
);

  logic [3:0] m1, m0, s1, s0;

  assign {m1, m0, s1, s0} = val;
  assign is_one = (val == 16'h0001);

  always_comb begin
    next = val;
    if (mode.dec) begin
      if (s0 != 4'd0) next[3:0] = s0 - 4'd1;
      else begin
        next[3:0] = DIGIT_MAX;
        if (s1 != 4'd0) next[7:4] = s1 - 4'd1;
        else begin
          // seconds underflow borrows a minute
          next[7:4] = SEC_TENS_MAX;
          if (m0 != 4'd0) next[11:8] = m0 - 4'd1;
          else begin
            next[11:8]  = DIGIT_MAX;
            next[15:12] = (m1 != 4'd0) ? m1 - 4'd1 : DIGIT_MAX;
          end
        end
      end
    end else begin
      if (mode.inc_sec) begin
        if (s0 == DIGIT_MAX) begin
          next[3:0] = 4'd0;
          next[7:4] = (s1 == SEC_TENS_MAX) ? 4'd0 : s1 + 4'd1;
        end else begin
          next[3:0] = s0 + 4'd1;
        end
      end
      if (mode.inc_min) begin
        if (val[15:8] == MIN_MAX) next[15:8] = 8'h00;
        else if (m0 == DIGIT_MAX) begin
          next[11:8]  = 4'd0;
          next[15:12] = m1 + 4'd1;
        end else begin
          next[11:8] = m0 + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmss_countdown.sv
// BCD mm:ss countdown timer with run/pause/expire control and 1 Hz prescaler.
// Define TIMER_RELOAD_EN for periodic interval mode (reload preset on expiry).
module mmss_countdown
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        inc_min,
  input  logic        inc_sec,
  output logic [15:0] sec,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  timer_state_t  state, state_n;
  logic [15:0]   sec_n, preset, preset_n, step_val;
  logic [PW-1:0] presc, presc_n;
  logic          done_n, tick, is_one;
  step_mode_t    mode;

  assign tick = (state == ST_RUN) && (presc == PRESC_MAX);
  assign mode = '{dec: tick,
                  inc_min: (state == ST_IDLE) && inc_min,
                  inc_sec: (state == ST_IDLE) && inc_sec};

  bcd_mmss_step u_step (
    .val    (sec),
    .mode   (mode),
    .next   (step_val),
    .is_one (is_one)
  );

  always_comb begin
    state_n  = state;
    sec_n    = sec;
    presc_n  = presc;
    preset_n = preset;
    done_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clear) sec_n = 16'h0000;
        else if (start_stop) begin
          if (sec != 16'h0000) begin
            state_n  = ST_RUN;
            preset_n = sec;
            presc_n  = '0;
          end
        end else if (inc_min || inc_sec) begin
          sec_n = step_val;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_n = ST_IDLE;
          sec_n   = 16'h0000;
          presc_n = '0;
        end else begin
          presc_n = tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (is_one) begin
              done_n = 1'b1;
`ifdef TIMER_RELOAD_EN
              sec_n  = preset;
`else
              sec_n   = 16'h0000;
              state_n = ST_EXPIRED;
`endif
            end else begin
              sec_n = step_val;
            end
          end
          // an expiring tick in the same cycle swallows the pause request
          if (start_stop && state_n != ST_EXPIRED) state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_n = ST_IDLE;
          sec_n   = 16'h0000;
          presc_n = '0;
        end else if (start_stop) begin
          state_n = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        sec_n = 16'h0000;
        if (clear || start_stop) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sec     <= 16'h0000;
      presc   <= '0;
      preset  <= 16'h0000;
      done    <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_n;
      sec     <= sec_n;
      presc   <= presc_n;
      preset  <= preset_n;
      done    <= done_n;
      running <= (state_n == ST_RUN);
      alarm   <= (state_n == ST_EXPIRED);
    end
  end

endmodule

// File: tb/tb_mmss_countdown.sv
// Scoreboard bench for mmss_countdown: directed plan plus random pulses,
// checked against a minutes/seconds integer model of the timer.
module tb_mmss_countdown;

  localparam int CLK_HZ = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic        inc_min = 1'b0, inc_sec = 1'b0;
  logic [15:0] sec;
  logic        running, done, alarm;

  always #5 clk = ~clk;

  mmss_countdown #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .inc_min    (inc_min),
    .inc_sec    (inc_sec),
    .sec        (sec),
    .running    (running),
    .done       (done),
    .alarm      (alarm)
  );

  typedef struct packed {
    logic [15:0] sec;
    logic        running;
    logic        done;
    logic        alarm;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  // reference model: plain integer minutes/seconds and a cycle counter
  int md = M_IDLE, mm = 0, ms = 0, pc = 0, pm = 0, ps = 0;
  bit mdone = 1'b0;

  function automatic obs_t model_obs();
    obs_t o;
    o.sec     = {4'(mm / 10), 4'(mm % 10), 4'(ms / 10), 4'(ms % 10)};
    o.running = (md == M_RUN);
    o.done    = mdone;
    o.alarm   = (md == M_EXP);
    return o;
  endfunction

  task automatic model_step(input bit r, input bit ss, input bit cl,
                            input bit im, input bit is);
    int  total;
    bit  expired;
    mdone = 1'b0;
    if (r) begin
      md = M_IDLE; mm = 0; ms = 0; pc = 0; pm = 0; ps = 0;
    end else begin
      case (md)
        M_IDLE: begin
          if (cl) begin mm = 0; ms = 0; end
          else if (ss) begin
            if (mm != 0 || ms != 0) begin md = M_RUN; pm = mm; ps = ms; pc = 0; end
          end else begin
            if (im) mm = (mm + 1) % 100;
            if (is) ms = (ms + 1) % 60;
          end
        end
        M_RUN: begin
          if (cl) begin md = M_IDLE; mm = 0; ms = 0; pc = 0; end
          else begin
            expired = 1'b0;
            if (pc == CLK_HZ - 1) begin
              pc = 0;
              total = mm * 60 + ms - 1;
              if (total == 0) begin
                mdone = 1'b1;
`ifdef TIMER_RELOAD_EN
                mm = pm; ms = ps;
`else
                mm = 0; ms = 0; md = M_EXP; expired = 1'b1;
`endif
              end else begin
                mm = total / 60; ms = total % 60;
              end
            end else begin
              pc = pc + 1;
            end
            if (ss && !expired) md = M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (cl) begin md = M_IDLE; mm = 0; ms = 0; pc = 0; end
          else if (ss) md = M_RUN;
        end
        default: if (ss || cl) md = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit ss, input bit cl, input bit im, input bit is);
    rst = r; start_stop = ss; clear = cl; inc_min = im; inc_sec = is;
    model_step(r, ss, cl, im, is);
    @(posedge clk);
    exp_q.push_back(model_obs());
    #1;
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic set_val(input int mins, input int secs);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < mins; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < secs; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // monitor: one expected observation per clock edge
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{sec: sec, running: running, done: done, alarm: alarm};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: sec=%h run=%b done=%b alarm=%b, want sec=%h run=%b done=%b alarm=%b",
                   $time, a.sec, a.running, a.done, a.alarm, e.sec, e.running, e.done, e.alarm);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_sec", sec, 16'h0000);
    chk("reset_flags", {13'd0, running, done, alarm}, 16'h0000);

    // 01:03, run one second
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    chk("set_0103", sec, 16'h0103);
    step(0, 1, 0, 0, 0);
    chk("run_start", {15'd0, running}, 16'h0001);
    idle(9);
    chk("before_tick", sec, 16'h0103);
    idle(1);
    chk("first_tick", sec, 16'h0102);

    // borrow cases
    set_val(1, 0); step(0, 1, 0, 0, 0); idle(10);
    chk("borrow_0100", sec, 16'h0059);
    set_val(10, 0); step(0, 1, 0, 0, 0); idle(10);
    chk("borrow_1000", sec, 16'h0959);

    // expiry
    set_val(0, 2); step(0, 1, 0, 0, 0); idle(20);
`ifndef TIMER_RELOAD_EN
    chk("expire_sec", sec, 16'h0000);
    chk("expire_done_alarm", {14'd0, done, alarm}, 16'h0003);
    idle(1);
    chk("done_one_cycle", {14'd0, done, alarm}, 16'h0001);
    step(0, 1, 0, 0, 0);
    chk("alarm_clear", {14'd0, running, alarm}, 16'h0000);
`endif

    // pause with prescaler held at 4
    set_val(0, 5); step(0, 1, 0, 0, 0); idle(3);
    step(0, 1, 0, 0, 0); idle(50);
    chk("pause_hold", sec, 16'h0005);
    step(0, 1, 0, 0, 0); idle(5);
    chk("resume_early", sec, 16'h0005);
    idle(1);
    chk("resume_tick", sec, 16'h0004);

    // wraps and start at zero
    set_val(0, 60);
    chk("sec_wrap", sec, 16'h0000);
    set_val(100, 0);
    chk("min_wrap", sec, 16'h0000);
    set_val(99, 59);
    chk("max_value", sec, 16'h9959);
    step(0, 0, 1, 0, 0); step(0, 1, 0, 0, 0);
    chk("start_at_zero", {15'd0, running}, 16'h0000);

    // clear beats start_stop in RUN
    set_val(0, 3); step(0, 1, 0, 0, 0); idle(3);
    step(0, 1, 1, 0, 0);
    chk("clear_wins", {sec[14:0], running}, 16'h0000);

    // long run through expiry / reload
    set_val(0, 3); step(0, 1, 0, 0, 0); idle(70);

    // reset mid-count loses the preset
    set_val(0, 5); step(0, 1, 0, 0, 0); idle(15);
    step(1, 0, 0, 0, 0);
    chk("rst_mid", {sec[14:0], running}, 16'h0000);
    step(0, 1, 0, 0, 0);
    chk("rst_preset_lost", {15'd0, running}, 16'h0000);

    // random pulses
    for (int i = 0; i < 3000; i++)
      step($urandom_range(999) == 0, $urandom_range(39) == 0, $urandom_range(149) == 0,
           $urandom_range(5) == 0, $urandom_range(5) == 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
